status_cond_unit: RTL and testbench

STATUS_COND_UNIT -- requirements
Module: status_cond_unit

---
 rtl/status_cond_unit.sv | 136 +++++++++++++
 tb/tb_status_cond_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/status_cond_unit.sv
// status_cond_unit: status flag register plus NUM_CH independent
// condition-code evaluators with optional registered result stage.
// Optional feature: define COND_FWD_EN to forward same-cycle status
// writes (sr_in) into the condition evaluators.
module status_cond_unit #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sr_we,
  input  logic [3:0]          sr_in,
  input  logic                freeze,
  input  logic                flush,
  input  logic [4*NUM_CH-1:0] cond,
  input  logic [NUM_CH-1:0]   cond_valid,
  output logic [NUM_CH-1:0]   cond_pass,
  output logic [NUM_CH-1:0]   pass_valid,
  output logic [3:0]          sr
);

  localparam int unsigned FLAG_W = 4;

  logic [FLAG_W-1:0] sr_q;
  logic [FLAG_W-1:0] sr_d;
  logic [FLAG_W-1:0] eval_flags;
  logic [NUM_CH-1:0] raw_pass;
  logic              sr_wr_en;

  // Evaluate one condition code against flags packed {z, c, n, v}
  function automatic logic eval_cond(input logic [3:0] code, input logic [FLAG_W-1:0] f);
    logic z, c, n, v;
    logic res;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    unique case (code)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign sr_wr_en = sr_we & ~freeze;

  // Status register next-state: load on unstalled write, otherwise hold
  always_comb begin
    sr_d = sr_q;
    if (sr_wr_en) begin
      sr_d = sr_in;
    end
  end

  // Status register; flush intentionally has no effect here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr = sr_q;

`ifdef COND_FWD_EN
  // Same-cycle forwarding of the flags being written
  assign eval_flags = sr_wr_en ? sr_in : sr_q;
`else
  // Evaluation sees the committed status register only
  assign eval_flags = sr_q;
`endif

  // Per-channel evaluation, all channels in parallel; invalid channels read 0
  always_comb begin
    raw_pass = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      raw_pass[k] = cond_valid[k] & eval_cond(cond[4*k +: 4], eval_flags);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [NUM_CH-1:0] pass_q;
      logic [NUM_CH-1:0] pass_d;
      logic [NUM_CH-1:0] valid_q;
      logic [NUM_CH-1:0] valid_d;

      // Output stage next-state: flush clears, freeze holds, else capture
      always_comb begin
        pass_d  = pass_q;
        valid_d = valid_q;
        if (flush) begin
          pass_d  = '0;
          valid_d = '0;
        end else if (!freeze) begin
          pass_d  = raw_pass;
          valid_d = cond_valid;
        end
      end

      // Output registers, one cycle of latency
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pass_q  <= '0;
          valid_q <= '0;
        end else begin
          pass_q  <= pass_d;
          valid_q <= valid_d;
        end
      end

      assign cond_pass  = pass_q;
      assign pass_valid = valid_q;
    end else begin : g_out_comb
      // Zero-latency results, forced low while reset is asserted
      assign cond_pass  = rst_n ? raw_pass   : NUM_CH'(0);
      assign pass_valid = rst_n ? cond_valid : NUM_CH'(0);
    end
  endgenerate

endmodule

// File: tb/tb_status_cond_unit.sv
// Directed testbench for status_cond_unit: registered instance (dut)
// and combinational instance (dut_c) share all inputs.
module tb_status_cond_unit;

  logic       clk;
  logic       rst_n;
  logic       sr_we;
  logic [3:0] sr_in;
  logic       freeze;
  logic       flush;
  logic [7:0] cond;
  logic [1:0] cond_valid;
  logic [1:0] cond_pass;
  logic [1:0] pass_valid;
  logic [3:0] sr;
  logic [1:0] cond_pass_c;
  logic [1:0] pass_valid_c;
  logic [3:0] sr_c;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef COND_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  status_cond_unit #(.NUM_CH(2), .OUT_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .sr_we(sr_we), .sr_in(sr_in),
    .freeze(freeze), .flush(flush), .cond(cond), .cond_valid(cond_valid),
    .cond_pass(cond_pass), .pass_valid(pass_valid), .sr(sr)
  );

  status_cond_unit #(.NUM_CH(2), .OUT_REG(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .sr_we(sr_we), .sr_in(sr_in),
    .freeze(freeze), .flush(flush), .cond(cond), .cond_valid(cond_valid),
    .cond_pass(cond_pass_c), .pass_valid(pass_valid_c), .sr(sr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sr_we = 1'b1; sr_in = 4'b1111; freeze = 1'b0; flush = 1'b0;
    cond = 8'hEE; cond_valid = 2'b11;
    tick(); tick();
    total_cnt++;
    if (sr !== 4'b0000) $display("FAIL reset_sr: got %b expected 0000", sr);
    else pass_cnt++;
    total_cnt++;
    if (cond_pass !== 2'b00 || pass_valid !== 2'b00)
      $display("FAIL reset_out: got pass=%b valid=%b expected 00/00", cond_pass, pass_valid);
    else pass_cnt++;
    total_cnt++;
    if (cond_pass_c !== 2'b00 || pass_valid_c !== 2'b00)
      $display("FAIL reset_out_comb: got pass=%b valid=%b expected 00/00", cond_pass_c, pass_valid_c);
    else pass_cnt++;
    sr_we = 1'b0; sr_in = 4'b0000; cond = 8'h00; cond_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    sr_we = 1'b1; sr_in = 4'b1000;
    tick();
    sr_we = 1'b0;
    total_cnt++;
    if (sr !== 4'b1000) $display("FAIL write_sr: got %b expected 1000", sr);
    else pass_cnt++;
  endtask

  task automatic test_ge_le();
    sr_we = 1'b1; sr_in = 4'b0011;
    tick();
    sr_we = 1'b0;
    // ch1 LE (0), ch0 GE (1)
    cond = {4'b1101, 4'b1010}; cond_valid = 2'b11;
    #1;
    total_cnt++;
    if (cond_pass_c !== 2'b01) $display("FAIL ge_le_comb: got %b expected 01", cond_pass_c);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cond_pass !== 2'b01 || pass_valid !== 2'b11)
      $display("FAIL ge_le_reg: got pass=%b valid=%b expected 01/11", cond_pass, pass_valid);
    else pass_cnt++;
    cond_valid = 2'b00;
    sr_we = 1'b1; sr_in = 4'b0010;
    tick();
    sr_we = 1'b0;
    // ch1 GT (0), ch0 LE (1) with n=1 v=0
    cond = {4'b1100, 4'b1101}; cond_valid = 2'b11;
    tick();
    total_cnt++;
    if (cond_pass !== 2'b01) $display("FAIL le_nv: got %b expected 01", cond_pass);
    else pass_cnt++;
  endtask

  task automatic test_multi_channel();
    sr_we = 1'b1; sr_in = 4'b1000; cond_valid = 2'b00;
    tick();
    sr_we = 1'b0;
    cond = {4'b0001, 4'b0000}; cond_valid = 2'b11;
    #1;
    total_cnt++;
    if (pass_valid !== 2'b00) $display("FAIL multi_latency: got valid=%b expected 00", pass_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cond_pass !== 2'b01 || pass_valid !== 2'b11)
      $display("FAIL multi_indep: got pass=%b valid=%b expected 01/11", cond_pass, pass_valid);
    else pass_cnt++;
  endtask

  task automatic test_freeze_flush();
    freeze = 1'b1; sr_we = 1'b1; sr_in = 4'b0100;
    cond = {4'b1110, 4'b1110}; cond_valid = 2'b11;
    tick();
    total_cnt++;
    if (sr !== 4'b1000) $display("FAIL freeze_sr: got %b expected 1000", sr);
    else pass_cnt++;
    total_cnt++;
    if (cond_pass !== 2'b01 || pass_valid !== 2'b11)
      $display("FAIL freeze_out: got pass=%b valid=%b expected 01/11", cond_pass, pass_valid);
    else pass_cnt++;
    flush = 1'b1;
    tick();
    total_cnt++;
    if (cond_pass !== 2'b00 || pass_valid !== 2'b00)
      $display("FAIL flush_out: got pass=%b valid=%b expected 00/00", cond_pass, pass_valid);
    else pass_cnt++;
    total_cnt++;
    if (sr !== 4'b1000) $display("FAIL flush_sr: got %b expected 1000", sr);
    else pass_cnt++;
    freeze = 1'b0;
    sr_in = 4'b0110;
    tick();
    total_cnt++;
    if (sr !== 4'b0110 || cond_pass !== 2'b00)
      $display("FAIL flush_keeps_sr_write: got sr=%b pass=%b expected 0110/00", sr, cond_pass);
    else pass_cnt++;
    flush = 1'b0; sr_we = 1'b0; cond_valid = 2'b00;
  endtask

  task automatic test_forward();
    sr_we = 1'b1; sr_in = 4'b0000;
    tick();
    sr_in = 4'b1000;
    cond = {4'b1111, 4'b0000}; cond_valid = 2'b01;
    #1;
    total_cnt++;
    if (cond_pass_c !== {1'b0, FWD}) $display("FAIL fwd_comb: got %b expected %b", cond_pass_c, {1'b0, FWD});
    else pass_cnt++;
    tick();
    sr_we = 1'b0;
    total_cnt++;
    if (cond_pass !== {1'b0, FWD} || sr !== 4'b1000)
      $display("FAIL fwd_reg: got pass=%b sr=%b expected %b/1000", cond_pass, sr, {1'b0, FWD});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cond_pass !== 2'b01) $display("FAIL fwd_next: got %b expected 01", cond_pass);
    else pass_cnt++;
  endtask

  task automatic test_invalid_never();
    // ch1 AL but invalid, ch0 NV valid
    cond = {4'b1110, 4'b1111}; cond_valid = 2'b01;
    #1;
    total_cnt++;
    if (cond_pass_c !== 2'b00 || pass_valid_c !== 2'b01)
      $display("FAIL inv_comb: got pass=%b valid=%b expected 00/01", cond_pass_c, pass_valid_c);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cond_pass !== 2'b00 || pass_valid !== 2'b01)
      $display("FAIL inv_reg: got pass=%b valid=%b expected 00/01", cond_pass, pass_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    cond = {4'b1110, 4'b1110}; cond_valid = 2'b11;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (cond_pass !== 2'b00 || pass_valid !== 2'b00 || sr !== 4'b0000)
      $display("FAIL async_reset: got pass=%b valid=%b sr=%b expected 00/00/0000", cond_pass, pass_valid, sr);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    sr_we = 1'b1; sr_in = 4'b0001;
    cond = {4'b0110, 4'b1110}; cond_valid = 2'b01;
    tick();
    sr_we = 1'b0;
    total_cnt++;
    if (sr !== 4'b0001 || cond_pass !== 2'b01 || pass_valid !== 2'b01)
      $display("FAIL first_edge: got sr=%b pass=%b valid=%b expected 0001/01/01", sr, cond_pass, pass_valid);
    else pass_cnt++;
    cond = {4'b0110, 4'b0111}; cond_valid = 2'b11;
    tick();
    total_cnt++;
    if (cond_pass !== 2'b10) $display("FAIL vs_vc: got %b expected 10", cond_pass);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_ge_le();
    test_multi_channel();
    test_freeze_flush();
    test_forward();
    test_invalid_never();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
